// File: rtl/scanchain_write_arbiter_pkg.sv
// Shared scan-chain definitions: default address/payload widths and the write arbiter FSM encoding.
package scanchain_write_arbiter_pkg;

  // Also used by the UART scan client so both ends agree on the scan word layout.
  localparam int unsigned ScanAddrBits    = 12;
  localparam int unsigned ScanPayloadBits = 169;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StHold = 1'b1
  } arb_state_e;

  // Index width for n requesters; never narrower than one bit.
  function automatic int unsigned idx_bits(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scanchain_write_arbiter_if.sv
// Requester-side and scan-writer-side valid/ready channels of the scan-chain write arbiter.
interface scanchain_write_arbiter_if
  import scanchain_write_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned ADDR_BITS    = ScanAddrBits,
  parameter int unsigned PAYLOAD_BITS = ScanPayloadBits
) ();

  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ-1:0]              req_ready;
  logic [NUM_REQ*ADDR_BITS-1:0]    req_addr;
  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_payload;
  logic [NUM_REQ-1:0]              req_reset;

  logic                    write_valid;
  logic                    write_ready;
  logic [ADDR_BITS-1:0]    write_addr;
  logic [PAYLOAD_BITS-1:0] write_payload;
  logic                    write_reset;

  // Arbiter side.
  modport slave (
    input  req_valid, req_addr, req_payload, req_reset, write_ready,
    output req_ready, write_valid, write_addr, write_payload, write_reset
  );

  // Requesters plus scan-chain writer side.
  modport master (
    output req_valid, req_addr, req_payload, req_reset, write_ready,
    input  req_ready, write_valid, write_addr, write_payload, write_reset
  );

endinterface

// File: rtl/scanchain_write_arbiter_rr_priority_select.sv
// Combinational rotating-priority selector: first set request at or after the pointer wins.
module rr_priority_select #(
  parameter int unsigned NumReq  = 2,
  parameter int unsigned IdxBits = 1
) (
  input  logic [NumReq-1:0]  req_i,
  input  logic [IdxBits-1:0] ptr_i,
  output logic [NumReq-1:0]  gnt_o,
  output logic [IdxBits-1:0] idx_o,
  output logic               valid_o
);

  logic [IdxBits-1:0] pos;
  logic               found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    pos   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      pos = IdxBits'((32'(ptr_i) + k) % NumReq);
      if (!found && req_i[pos]) begin
        found      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = pos;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/scanchain_write_arbiter.sv
// Round-robin arbiter sharing the scan-chain write port; holds each granted write in a one-entry
// register until the writer accepts it and counts completed writes.
module scanchain_write_arbiter
  import scanchain_write_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned ADDR_BITS    = ScanAddrBits,
  parameter int unsigned PAYLOAD_BITS = ScanPayloadBits,
  parameter int unsigned CNT_BITS     = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  scanchain_write_arbiter_if.slave     bus,
  output logic [idx_bits(NUM_REQ)-1:0] grant_id_o,
  output logic [CNT_BITS-1:0]          xfer_count_o
);

  localparam int unsigned IdxBits = idx_bits(NUM_REQ);

  arb_state_e              state_q, state_d;
  logic [IdxBits-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IdxBits-1:0]      grant_q, grant_d;
  logic                    write_valid_q, write_valid_d;
  logic [ADDR_BITS-1:0]    write_addr_q, write_addr_d;
  logic [PAYLOAD_BITS-1:0] write_payload_q, write_payload_d;
  logic                    write_reset_q, write_reset_d;
  logic [CNT_BITS-1:0]     xfer_count_q, xfer_count_d;
  logic [NUM_REQ-1:0]      req_ready;

  logic [NUM_REQ-1:0] sel_gnt;
  logic [IdxBits-1:0] sel_idx;
  logic               sel_valid;

  rr_priority_select #(
    .NumReq  (NUM_REQ),
    .IdxBits (IdxBits)
  ) u_rr_priority_select (
    .req_i   (bus.req_valid),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (sel_gnt),
    .idx_o   (sel_idx),
    .valid_o (sel_valid)
  );

  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    grant_d         = grant_q;
    write_valid_d   = write_valid_q;
    write_addr_d    = write_addr_q;
    write_payload_d = write_payload_q;
    write_reset_d   = write_reset_q;
    xfer_count_d    = xfer_count_q;
    req_ready       = '0;

    unique case (state_q)
      StIdle: begin
        // Gating with reset_n keeps req_ready low for the whole reset pulse.
        if (sel_valid && reset_n) begin
          req_ready       = sel_gnt;
          grant_d         = sel_idx;
          write_valid_d   = 1'b1;
          write_addr_d    = bus.req_addr[sel_idx*ADDR_BITS +: ADDR_BITS];
          write_payload_d = bus.req_payload[sel_idx*PAYLOAD_BITS +: PAYLOAD_BITS];
          write_reset_d   = bus.req_reset[sel_idx];
          state_d         = StHold;
        end
      end
      StHold: begin
        if (bus.write_ready) begin
          write_valid_d = 1'b0;
          xfer_count_d  = xfer_count_q + 1'b1;
          rr_ptr_d      = (grant_q == IdxBits'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
          state_d       = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= StIdle;
      rr_ptr_q        <= '0;
      grant_q         <= '0;
      write_valid_q   <= 1'b0;
      write_addr_q    <= '0;
      write_payload_q <= '0;
      write_reset_q   <= 1'b0;
      xfer_count_q    <= '0;
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      grant_q         <= grant_d;
      write_valid_q   <= write_valid_d;
      write_addr_q    <= write_addr_d;
      write_payload_q <= write_payload_d;
      write_reset_q   <= write_reset_d;
      xfer_count_q    <= xfer_count_d;
    end
  end

  assign bus.req_ready     = req_ready;
  assign bus.write_valid   = write_valid_q;
  assign bus.write_addr    = write_addr_q;
  assign bus.write_payload = write_payload_q;
  assign bus.write_reset   = write_reset_q;
  assign grant_id_o        = grant_q;
  assign xfer_count_o      = xfer_count_q;

endmodule
